// File: rtl/rx_4channel_demux_pkg.sv
// Shared beat definitions for the 4-channel TX arbiter / RX demux pair.
// Word-count, beat width and beat bundle layout live here so both ends agree.
package rx_4channel_demux_pkg;

  localparam int NUM_DAT_WORDS = 8;
  localparam int LOG_DAT_WORDS = 4;
  localparam int BEAT_W        = 64 * NUM_DAT_WORDS;
  localparam int NUM_CHANS     = 4;

  typedef struct packed {
    logic [LOG_DAT_WORDS-1:0] num;
    logic [BEAT_W-1:0]        words;
    logic                     sop;
    logic [3:0]               eopbits;
  } beat_t;

  function automatic logic beat_is_last(input beat_t b);
    return |b.eopbits;
  endfunction

endpackage

// File: rtl/rx_4channel_demux_if.sv
// Merged input stream plus the four per-channel output ports of the RX demux.
// master drives the merged stream and consumes the ports; slave is the demux.
interface rx_4channel_demux_if;
  import rx_4channel_demux_pkg::*;

  logic [LOG_DAT_WORDS-1:0]           num_datwords_valid;
  logic [BEAT_W-1:0]                  datwords;
  logic [7:0]                         chan;
  logic                               sop;
  logic [3:0]                         eopbits;
  logic                               valid;
  logic                               ready;

  logic [NUM_CHANS*LOG_DAT_WORDS-1:0] out_num_words;
  logic [NUM_CHANS*BEAT_W-1:0]        out_words;
  logic [NUM_CHANS-1:0]               out_sop;
  logic [NUM_CHANS*4-1:0]             out_eopbits;
  logic [NUM_CHANS-1:0]               out_valid;
  logic [NUM_CHANS-1:0]               out_ready;
  logic [15:0]                        drop_count;
  logic [NUM_CHANS-1:0]               proto_err;

  modport master (
    output num_datwords_valid, datwords, chan, sop, eopbits, valid, out_ready,
    input  ready, out_num_words, out_words, out_sop, out_eopbits, out_valid,
           drop_count, proto_err
  );

  modport slave (
    input  num_datwords_valid, datwords, chan, sop, eopbits, valid, out_ready,
    output ready, out_num_words, out_words, out_sop, out_eopbits, out_valid,
           drop_count, proto_err
  );

endinterface

// File: rtl/rx_4channel_demux_fifo2.sv
// Per-channel 2-entry buffer with registered head, plus packet framing tracker.
// Head valid 1 cycle after push into empty buffer; full when both entries are held.
module rx_chan_fifo2
  import rx_4channel_demux_pkg::*;
(
  input  logic  clk,
  input  logic  arst,
  input  logic  i_push,
  input  beat_t i_beat,
  input  logic  i_rdy,
  output logic  o_vld,
  output logic  o_full,
  output beat_t o_head,
  output logic  o_proto_err
);

  logic [1:0] r_cnt;
  beat_t      r_head;
  beat_t      r_tail;
  logic       r_in_pkt;
  logic       r_proto_err;
  logic       w_pop;

  assign o_vld       = (r_cnt != 2'd0);
  assign o_full      = (r_cnt == 2'd2);
  assign o_head      = r_head;
  assign o_proto_err = r_proto_err;
  assign w_pop       = o_vld & i_rdy;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_cnt  <= 2'd0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_head <= i_beat;
          else               r_tail <= i_beat;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          // Count stays put; with one entry the incoming beat replaces the head.
          if (r_cnt == 2'd1) begin
            r_head <= i_beat;
          end else begin
            r_head <= r_tail;
            r_tail <= i_beat;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_in_pkt    <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_proto_err <= i_push & (i_beat.sop ? r_in_pkt : ~r_in_pkt);
      if (i_push)
        r_in_pkt <= (i_beat.sop | r_in_pkt) & ~beat_is_last(i_beat);
    end
  end

endmodule

// File: rtl/rx_4channel_demux.sv
// Steers the merged RX stream to four channel ports by chan ID; unmatched beats are dropped.
// 1-cycle latency to a port; input stalls whenever any port buffer is full.
module rx_4channel_demux
  import rx_4channel_demux_pkg::*;
#(
  parameter logic [7:0] CHANID0 = 8'h0,
  parameter logic [7:0] CHANID1 = 8'h1,
  parameter logic [7:0] CHANID2 = 8'h2,
  parameter logic [7:0] CHANID3 = 8'h3
) (
  input logic                clk,
  input logic                arst,
  rx_4channel_demux_if.slave dif
);

  logic [NUM_CHANS-1:0] w_full;
  logic [NUM_CHANS-1:0] w_vld;
  logic [NUM_CHANS-1:0] w_perr;
  logic [NUM_CHANS-1:0] w_sel;
  logic [NUM_CHANS-1:0] w_push;
  beat_t                w_head [NUM_CHANS];
  beat_t                w_in;
  logic                 w_live;
  logic                 w_acc;
  logic                 w_drop;
  logic [15:0]          r_drop_count;

  assign w_in.num     = dif.num_datwords_valid;
  assign w_in.words   = dif.datwords;
  assign w_in.sop     = dif.sop;
  assign w_in.eopbits = dif.eopbits;

  assign w_live    = dif.valid & (|dif.num_datwords_valid);
  assign dif.ready = &(~w_full);
  assign w_acc     = w_live & dif.ready;

  // Lowest-numbered port wins if two CHANIDs collide.
  always_comb begin
    w_sel = '0;
    if      (dif.chan == CHANID0) w_sel = 4'b0001;
    else if (dif.chan == CHANID1) w_sel = 4'b0010;
    else if (dif.chan == CHANID2) w_sel = 4'b0100;
    else if (dif.chan == CHANID3) w_sel = 4'b1000;
  end

  assign w_push = w_sel & {NUM_CHANS{w_acc}};
  assign w_drop = w_acc & ~(|w_sel);

  for (genvar gi = 0; gi < NUM_CHANS; gi++) begin : g_port
    rx_chan_fifo2 u_fifo (
      .clk         (clk),
      .arst        (arst),
      .i_push      (w_push[gi]),
      .i_beat      (w_in),
      .i_rdy       (dif.out_ready[gi]),
      .o_vld       (w_vld[gi]),
      .o_full      (w_full[gi]),
      .o_head      (w_head[gi]),
      .o_proto_err (w_perr[gi])
    );
  end

  always_comb begin
    dif.out_num_words = '0;
    dif.out_words     = '0;
    dif.out_sop       = '0;
    dif.out_eopbits   = '0;
    for (int n = 0; n < NUM_CHANS; n++) begin
      dif.out_num_words[n*LOG_DAT_WORDS +: LOG_DAT_WORDS] = w_head[n].num;
      dif.out_words[n*BEAT_W +: BEAT_W]                   = w_head[n].words;
      dif.out_sop[n]                                      = w_head[n].sop;
      dif.out_eopbits[n*4 +: 4]                           = w_head[n].eopbits;
    end
  end

  assign dif.out_valid  = w_vld;
  assign dif.proto_err  = w_perr;
  assign dif.drop_count = r_drop_count;

  always_ff @(posedge clk or posedge arst) begin
    if (arst)
      r_drop_count <= 16'h0;
    else if (w_drop && (r_drop_count != 16'hFFFF))
      r_drop_count <= r_drop_count + 16'h1;
  end

endmodule

// File: tb/tb_rx_4channel_demux.sv
// Randomized + directed bench for rx_4channel_demux against a queue-based reference model.
module tb_rx_4channel_demux;
  import rx_4channel_demux_pkg::*;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  rx_4channel_demux_if dif();
  rx_4channel_demux dut (.clk(clk), .arst(arst), .dif(dif));

  beat_t      mq [4][$];
  bit         m_inpkt [4];
  logic [3:0] m_perr;
  int         m_drop;
  logic [7:0] ids [4];
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [BEAT_W-1:0] got, input logic [BEAT_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mreset();
    for (int n = 0; n < 4; n++) begin
      mq[n].delete();
      m_inpkt[n] = 0;
    end
    m_perr = '0;
    m_drop = 0;
  endtask

  task automatic check_all();
    logic [3:0] ev;
    bit er;
    er = 1;
    for (int n = 0; n < 4; n++) begin
      ev[n] = (mq[n].size() != 0);
      if (mq[n].size() >= 2) er = 0;
    end
    chk("ready", dif.ready, er);
    chk("out_valid", dif.out_valid, ev);
    chk("proto_err", dif.proto_err, m_perr);
    chk("drop_count", dif.drop_count, m_drop[15:0]);
    for (int n = 0; n < 4; n++) begin
      if (ev[n]) begin
        chk("head_num", dif.out_num_words[n*LOG_DAT_WORDS +: LOG_DAT_WORDS], mq[n][0].num);
        chk("head_words", dif.out_words[n*BEAT_W +: BEAT_W], mq[n][0].words);
        chk("head_sop", dif.out_sop[n], mq[n][0].sop);
        chk("head_eop", dif.out_eopbits[n*4 +: 4], mq[n][0].eopbits);
      end
    end
  endtask

  // Called at posedge+1; checks at negedge, advances the model at the next posedge.
  task automatic cycle(output bit acc);
    bit rdy, live;
    int port;
    bit [3:0] pop;
    beat_t b;
    @(negedge clk);
    check_all();
    rdy = 1;
    for (int n = 0; n < 4; n++) if (mq[n].size() >= 2) rdy = 0;
    live = dif.valid && (dif.num_datwords_valid != 0);
    acc = live && rdy;
    port = -1;
    for (int n = 3; n >= 0; n--) if (dif.chan == ids[n]) port = n;
    b.num = dif.num_datwords_valid;
    b.words = dif.datwords;
    b.sop = dif.sop;
    b.eopbits = dif.eopbits;
    for (int n = 0; n < 4; n++) pop[n] = (mq[n].size() != 0) && dif.out_ready[n];
    @(posedge clk);
    for (int n = 0; n < 4; n++) if (pop[n]) void'(mq[n].pop_front());
    m_perr = '0;
    if (acc) begin
      if (port >= 0) begin
        m_perr[port] = b.sop ? m_inpkt[port] : !m_inpkt[port];
        if (b.sop) m_inpkt[port] = 1;
        if (b.eopbits != 0) m_inpkt[port] = 0;
        mq[port].push_back(b);
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [3:0] num,
                       input logic s, input logic [3:0] eop);
    dif.valid = v;
    dif.chan = c;
    dif.num_datwords_valid = num;
    dif.sop = s;
    dif.eopbits = eop;
    for (int w = 0; w < BEAT_W/32; w++) dif.datwords[w*32 +: 32] = $urandom;
  endtask

  task automatic idle(input int n);
    bit acc;
    dif.valid = 0;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic send(input logic [7:0] c, input logic [3:0] num, input logic s, input logic [3:0] eop);
    bit acc;
    acc = 0;
    drive(1, c, num, s, eop);
    for (int k = 0; k < 50 && !acc; k++) cycle(acc);
    chk("send_timeout", acc, 1);
    dif.valid = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    logic [15:0] d0;
    int r;
    ids[0] = 8'h00; ids[1] = 8'h01; ids[2] = 8'h02; ids[3] = 8'h03;
    mreset();
    dif.valid = 0; dif.chan = 0; dif.num_datwords_valid = 0; dif.sop = 0;
    dif.eopbits = 0; dif.datwords = '0; dif.out_ready = 4'hF;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", dif.out_valid, 0);
    chk("rst_words", |dif.out_words, 0);
    chk("rst_num", dif.out_num_words, 0);
    chk("rst_sop_eop", {dif.out_sop, dif.out_eopbits}, 0);
    chk("rst_drop", dif.drop_count, 0);
    chk("rst_perr", dif.proto_err, 0);
    chk("rst_ready", dif.ready, 1);
    arst = 0;
    @(posedge clk); #1;

    // single-beat packet to port 1
    send(8'h01, 4'd8, 1, 4'h8);
    chk("t1_vld", dif.out_valid, 4'b0010);
    chk("t1_num", dif.out_num_words[4 +: 4], 8);
    chk("t1_perr", dif.proto_err, 0);
    chk("t1_drop", dif.drop_count, 0);
    idle(2);

    // port 2 backpressure fills its buffer and stalls everyone
    dif.out_ready = 4'b1011;
    send(8'h02, 4'd8, 1, 4'h0);
    send(8'h02, 4'd4, 0, 4'h0);
    chk("t2_ready_lo", dif.ready, 0);
    drive(1, 8'h00, 4'd2, 1, 4'h1);
    for (int i = 0; i < 3; i++) cycle(acc);
    chk("t2_p0_blocked", dif.out_valid[0], 0);
    drive(1, 8'h02, 4'd5, 0, 4'h1);
    cycle(acc);
    dif.out_ready = 4'hF;
    send(8'h02, 4'd5, 0, 4'h1);
    send(8'h00, 4'd2, 1, 4'h1);
    chk("t2_p0_resumed", dif.out_valid[0], 1);
    idle(4);

    // unmatched chan is dropped
    d0 = dif.drop_count;
    for (int i = 0; i < 5; i++) send(8'h7F, 4'd3, 0, 4'h0);
    chk("t3_drop", dif.drop_count, d0 + 16'd5);
    chk("t3_novld", dif.out_valid, 0);
    idle(1);

    // double sop on port 0
    send(8'h00, 4'd1, 0, 4'h1);
    idle(1);
    send(8'h00, 4'd2, 1, 4'h0);
    send(8'h00, 4'd2, 1, 4'h0);
    chk("t4_perr", dif.proto_err, 4'b0001);
    idle(1);
    chk("t4_perr_clr", dif.proto_err, 0);
    send(8'h00, 4'd1, 0, 4'h2);
    idle(2);

    // zero-count beats are ignored
    d0 = dif.drop_count;
    drive(1, 8'h7F, 4'd0, 0, 4'h0);
    for (int i = 0; i < 3; i++) cycle(acc);
    drive(1, 8'h01, 4'd0, 1, 4'h1);
    for (int i = 0; i < 3; i++) cycle(acc);
    chk("t5_drop", dif.drop_count, d0);
    chk("t5_novld", dif.out_valid, 0);
    idle(1);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      dif.out_ready = 4'($urandom);
      r = $urandom_range(0, 5);
      drive($urandom_range(0, 3) != 0,
            (r < 4) ? 8'(r) : ((r == 4) ? 8'h7F : 8'($urandom)),
            4'($urandom_range(0, 8)), 1'($urandom),
            ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0);
      cycle(acc);
    end
    dif.out_ready = 4'hF;
    idle(4);

    // reset while port 3 holds two beats mid-packet
    dif.out_ready = 4'b0111;
    send(8'h03, 4'd8, 1, 4'h0);
    send(8'h03, 4'd8, 0, 4'h0);
    chk("t6_full_vld", dif.out_valid[3], 1);
    chk("t6_full_rdy", dif.ready, 0);
    #2 arst = 1;
    #1;
    chk("t6_rst_vld", dif.out_valid, 0);
    chk("t6_rst_rdy", dif.ready, 1);
    mreset();
    @(negedge clk);
    @(negedge clk);
    arst = 0;
    @(posedge clk); #1;
    dif.out_ready = 4'hF;
    send(8'h03, 4'd4, 0, 4'h0);
    chk("t6_perr", dif.proto_err, 4'b1000);
    idle(3);

    // long drop run to reach saturation
    drive(1, 8'h7F, 4'd1, 1, 4'h0);
    repeat (65540) @(posedge clk);
    #1;
    m_drop = (m_drop + 65540 > 65535) ? 65535 : m_drop + 65540;
    dif.valid = 0;
    @(negedge clk);
    chk("sat_drop", dif.drop_count, 16'hFFFF);
    @(posedge clk); #1;
    send(8'h7F, 4'd2, 0, 4'h0);
    idle(1);
    chk("sat_hold", dif.drop_count, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
